route_input_buffer: RTL

ROUTE_INPUT_BUFFER -- requirements
Module: route_input_buffer

---
 rtl/route_input_buffer_pkg.sv | 45 ++++
 rtl/route_input_buffer_fifo.sv | 51 +++++
 rtl/route_input_buffer.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/route_input_buffer_pkg.sv
// Shared NoC definitions: flit field offsets, router port indices,
// input-buffer FSM encoding and retry defaults.
package route_input_buffer_pkg;

  localparam int TILE_BITS_DEF  = 2;
  localparam int LOCAL_BITS_DEF = 2;
  localparam int MAX_RETRY_DEF  = 4;
  localparam int VC_BITS        = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_REQ     = 2'd1,
    S_BACKOFF = 2'd2
  } state_e;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_EAST  = 3'd1,
    PORT_WEST  = 3'd2,
    PORT_NORTH = 3'd3,
    PORT_SOUTH = 3'd4
  } port_e;

  // Field LSBs, packed upward from dest_ly at bit 0.
  function automatic int ly_lsb();
    return 0;
  endfunction

  function automatic int lx_lsb(int lb);
    return lb;
  endfunction

  function automatic int ty_lsb(int lb);
    return 2 * lb;
  endfunction

  function automatic int tx_lsb(int tb, int lb);
    return 2 * lb + tb;
  endfunction

  function automatic int vc_lsb(int tb, int lb);
    return 2 * lb + 2 * tb;
  endfunction

endpackage

// File: rtl/route_input_buffer_fifo.sv
// Flit FIFO with extra-bit wrap pointers; storage is not cleared,
// the pointers alone define what is valid.
module sync_fifo #(
  parameter int FLIT_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [FLIT_W-1:0]        wdata,
  input  logic                     pop,
  output logic [FLIT_W-1:0]        rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wptr_q, wptr_d;
  logic [AW:0]       rptr_q, rptr_d;
  logic [FLIT_W-1:0] mem_q [DEPTH];

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (push) wptr_d = wptr_q + (AW+1)'(1);
    if (pop)  rptr_d = rptr_q + (AW+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rptr_q[AW-1:0]];
  assign empty = (wptr_q == rptr_q);
  assign full  = (wptr_q[AW] != rptr_q[AW]) &&
                 (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign count = wptr_q - rptr_q;

endmodule

// File: rtl/route_input_buffer.sv
// Router input buffer: queues flits, presents the head to route compute,
// forwards on grant, backs off on retry and drops after repeated retries.
module route_input_buffer
  import route_input_buffer_pkg::*;
#(
  parameter int TILE_BITS  = TILE_BITS_DEF,
  parameter int LOCAL_BITS = LOCAL_BITS_DEF,
  parameter int FLIT_W     = 32,
  parameter int DEPTH      = 4,
  parameter int MAX_RETRY  = MAX_RETRY_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [FLIT_W-1:0]     in_flit,
  output logic                  pkt_valid,
  output logic [TILE_BITS-1:0]  dest_tile_x,
  output logic [TILE_BITS-1:0]  dest_tile_y,
  output logic [LOCAL_BITS-1:0] dest_lx,
  output logic [LOCAL_BITS-1:0] dest_ly,
  output logic [1:0]            vc_class,
  input  logic                  retry,
  input  logic                  grant,
  output logic                  out_valid,
  output logic [FLIT_W-1:0]     out_flit,
  output logic                  drop_pulse,
  output logic [2:0]            retry_cnt
);

  localparam int AW  = $clog2(DEPTH);
  localparam int LY  = ly_lsb();
  localparam int LX  = lx_lsb(LOCAL_BITS);
  localparam int TY  = ty_lsb(LOCAL_BITS);
  localparam int TX  = tx_lsb(TILE_BITS, LOCAL_BITS);
  localparam int VC  = vc_lsb(TILE_BITS, LOCAL_BITS);

  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic [AW:0]       count;
  logic [FLIT_W-1:0] head;
  logic [FLIT_W-1:0] head_v;
  logic              last_retry;
  logic              more;

  state_e            state_q, state_d;
  logic [2:0]        retry_cnt_q, retry_cnt_d;
  logic [2:0]        timer_q, timer_d;
  logic              out_valid_q, out_valid_d;
  logic              drop_q, drop_d;
  logic [FLIT_W-1:0] out_flit_q, out_flit_d;

  sync_fifo #(
    .FLIT_W (FLIT_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (in_flit),
    .pop   (pop),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign in_ready = !full;
  assign push     = in_valid && !full;
  assign head_v   = empty ? '0 : head;

  assign dest_ly     = head_v[LY +: LOCAL_BITS];
  assign dest_lx     = head_v[LX +: LOCAL_BITS];
  assign dest_tile_y = head_v[TY +: TILE_BITS];
  assign dest_tile_x = head_v[TX +: TILE_BITS];
  assign vc_class    = head_v[VC +: VC_BITS];

  assign pkt_valid  = (state_q == S_REQ);
  assign last_retry = (retry_cnt_q == 3'(MAX_RETRY - 1));
  // A same-cycle push keeps the buffer non-empty after the pop.
  assign more       = (count > (AW+1)'(1)) || push;

  always_comb begin
    state_d     = state_q;
    retry_cnt_d = retry_cnt_q;
    timer_d     = timer_q;
    out_valid_d = 1'b0;
    drop_d      = 1'b0;
    out_flit_d  = out_flit_q;
    pop         = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) state_d = S_REQ;
      end
      S_REQ: begin
        if (grant || (retry && last_retry)) begin
          pop         = 1'b1;
          out_valid_d = grant;
          drop_d      = !grant;
          if (grant) out_flit_d = head;
          retry_cnt_d = 3'd0;
          state_d     = more ? S_REQ : S_IDLE;
        end else if (retry) begin
          retry_cnt_d = retry_cnt_q + 3'd1;
          timer_d     = retry_cnt_q + 3'd1;
          state_d     = S_BACKOFF;
        end
      end
      S_BACKOFF: begin
        timer_d = timer_q - 3'd1;
        if (timer_q == 3'd1) state_d = S_REQ;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      retry_cnt_q <= 3'd0;
      timer_q     <= 3'd0;
      out_valid_q <= 1'b0;
      drop_q      <= 1'b0;
      out_flit_q  <= '0;
    end else begin
      state_q     <= state_d;
      retry_cnt_q <= retry_cnt_d;
      timer_q     <= timer_d;
      out_valid_q <= out_valid_d;
      drop_q      <= drop_d;
      out_flit_q  <= out_flit_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign drop_pulse = drop_q;
  assign out_flit   = out_flit_q;
  assign retry_cnt  = retry_cnt_q;

endmodule
